calc_rr_engine: RTL and testbench
=================================

# calc_rr_engine

Parametrised next-generation calculator engine: NCH independent request channels share one add/sub unit and one shift unit through per-channel command FIFOs and round-robin arbitration. Each channel may have up to DEPTH commands outstanding, each carrying a tag that is returned with its response. The block adds shifts and overflow/invalid detection, and sits between the channel request drivers and the response collectors.

## Interface
- NCH, default 4: number of channels (2..8).
- DW, default 32: operand/result width (8..64, power of 2).
- DEPTH, default 4: per-channel command FIFO depth (power of 2, ≥2).
- TW, default 2: tag width.
- c_clk  in  1: clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-low reset.
- req_cmd_in  in  NCH*4: per-channel command; 0 = NOP.
- req_data_in  in  NCH*DW: op1 in the command cycle, op2 in the following cycle.
- req_tag_in  in  NCH*TW: tag, sampled in the command cycle.
- req_busy  out  NCH: channel cannot accept a command this cycle.
- out_resp  out  NCH*2: 0 none, 1 success, 2 overflow/invalid command.
- out_data  out  NCH*DW: result; 0 when out_resp ≠ 1.
- out_tag  out  NCH*TW: tag of the response; 0 when out_resp = 0.

## Operation
- Per-channel capture FSM, IDLE → OP2 → IDLE:
  - IDLE with req_cmd_in ≠ 0 and req_busy low: latch cmd, op1 and tag; go to OP2.
  - OP2: latch op2 and push {cmd, op1, op2, tag} to the channel FIFO; return to IDLE. req_cmd_in is ignored in OP2.
  - A command presented while req_busy is high is dropped, together with its following data cycle, and produces no response.
- req_busy = (FIFO count + (FSM in OP2 ? 1 : 0)) ≥ DEPTH; combinational from registered state.
- Command classes:
  - 1 ADD: op1 + op2. Carry out → resp 2, data 0.
  - 2 SUB: op1 − op2. op2 > op1 → resp 2, data 0.
  - 5 SHL: op1 << op2[log2(DW)-1:0], zero fill.
  - 6 SHR: op1 >> op2[log2(DW)-1:0], zero fill. Shifts never overflow.
  - Any other nonzero value is invalid and occupies an arith-unit slot → resp 2, data 0.
- Arbitration: each cycle the arith unit grants one channel whose FIFO head is ADD, SUB or invalid, and the shift unit grants one channel whose head is SHL or SHR.
  - Round-robin per unit: search starts at rr_ptr; after a grant, rr_ptr = granted + 1 mod NCH.
  - A granted head pops in that cycle.
  - Only the FIFO head is eligible, so a channel gets at most one grant per cycle and its responses stay in its own issue order.
- Push and pop on the same FIFO in the same cycle are allowed at any count.

## Timing
- Command at cycle T, op2 at T+1, FIFO write at the end of T+1, earliest grant in T+2.
- out_resp/out_data/out_tag are registered and valid in T+3 for exactly one cycle, then return to 0 unless another response follows back-to-back.
- A channel may issue its next command at T+2; sustained throughput is one command per 2 cycles per channel.
- With k channels contending for one unit, worst-case extra wait is k−1 cycles.
- Reset asserted, asynchronously:
  - out_resp, out_data, out_tag and req_busy go to 0.
  - FIFOs are emptied, FSMs return to IDLE, both rr_ptr are set to 0.
  - In-flight commands are discarded with no response, including a command reset mid-OP2.
- First command is accepted on the first rising edge after reset deasserts.

## Test plan
- Ch0 ADD, op1 5, op2 7, tag 1 at T → T+3: out_resp[0] = 1, out_data 12, out_tag 1; all outputs 0 at T+4.
- Ch1 ADD 0xFFFFFFFF + 1 → resp 2, data 0. Ch1 SUB 3 − 4 → resp 2. Ch1 SUB 4 − 3 → resp 1, data 1. Ch1 cmd 9 → resp 2, data 0.
- Ch2 SHL 1 by 31 → 0x80000000. SHR 0x80000000 by 33 (low 5 bits = 1) → 0x40000000. Both resp 1.
- All 4 channels issue ADD in the same cycle → responses on ch0, ch1, ch2, ch3 in T+3..T+6. Repeat the same cycle pattern → order ch0..ch3 again (rr_ptr back at 0). Simultaneous ADD on ch0 and SHL on ch1 → both respond at T+3.
- Stall one unit so ch0 fills: after DEPTH commands req_busy[0] = 1. A further command (tag 3) gets no response; the DEPTH accepted tags return in issue order.
- Reset asserted during OP2 of a ch0 command → no response ever for it, all outputs 0, req_busy 0. After release, ADD 2 + 2 → 4 at T+3.

Source files
------------

// File: rtl/calc_rr_engine.sv
// calc_rr_engine: NCH request channels, each with a two-cycle command capture FSM and a
// command FIFO, sharing one add/sub unit and one shift unit through round-robin arbitration.
module calc_rr_engine #(
    parameter int NCH   = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int TW    = 2
) (
    input  logic                c_clk,
    input  logic                reset,
    input  logic [NCH*4-1:0]    req_cmd_in,
    input  logic [NCH*DW-1:0]   req_data_in,
    input  logic [NCH*TW-1:0]   req_tag_in,
    output logic [NCH-1:0]      req_busy,
    output logic [NCH*2-1:0]    out_resp,
    output logic [NCH*DW-1:0]   out_data,
    output logic [NCH*TW-1:0]   out_tag
);

    localparam int SHW = $clog2(DW);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int RW  = $clog2(NCH);

    localparam logic [3:0] CMD_ADD  = 4'd1;
    localparam logic [3:0] CMD_SUB  = 4'd2;
    localparam logic [3:0] CMD_SHL  = 4'd5;
    localparam logic [3:0] CMD_SHR  = 4'd6;
    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OP2  = 1'b1
    } cap_state_t;

    // Result of one command as {resp, data}; data is forced to 0 on any error.
    function automatic logic [DW+1:0] calc_exec(input logic [3:0]    cmd,
                                                input logic [DW-1:0] op1,
                                                input logic [DW-1:0] op2);
        logic [DW:0]   sum;
        logic [DW-1:0] res;
        logic [1:0]    resp;
        sum  = {1'b0, op1} + {1'b0, op2};
        res  = '0;
        resp = RESP_ERR;
        case (cmd)
            CMD_ADD: begin
                if (sum[DW]) begin
                    resp = RESP_ERR;
                    res  = '0;
                end else begin
                    resp = RESP_OK;
                    res  = sum[DW-1:0];
                end
            end
            CMD_SUB: begin
                if (op2 > op1) begin
                    resp = RESP_ERR;
                    res  = '0;
                end else begin
                    resp = RESP_OK;
                    res  = op1 - op2;
                end
            end
            CMD_SHL: begin
                resp = RESP_OK;
                res  = op1 << op2[SHW-1:0];
            end
            CMD_SHR: begin
                resp = RESP_OK;
                res  = op1 >> op2[SHW-1:0];
            end
            default: begin
                resp = RESP_ERR;
                res  = '0;
            end
        endcase
        return {resp, res};
    endfunction

    // Returns {valid, index}. Scanning from the farthest position back toward ptr lets the
    // closest eligible channel overwrite earlier picks, so no "found" flag is needed.
    function automatic logic [RW:0] rr_pick(input logic [NCH-1:0] elig,
                                            input logic [RW-1:0]  ptr);
        logic [RW:0] pick;
        int          idx;
        pick = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NCH;
            if (elig[RW'(idx)]) begin
                pick = {1'b1, RW'(idx)};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [RW-1:0] rr_next(input logic [RW-1:0] idx);
        return (idx == RW'(NCH - 1)) ? RW'(0) : idx + RW'(1);
    endfunction

    cap_state_t      r_state     [NCH];
    cap_state_t      w_state_nxt [NCH];
    logic [3:0]      r_cap_cmd   [NCH];
    logic [DW-1:0]   r_cap_op1   [NCH];
    logic [TW-1:0]   r_cap_tag   [NCH];

    logic [3:0]      r_f_cmd     [NCH][DEPTH];
    logic [DW-1:0]   r_f_op1     [NCH][DEPTH];
    logic [DW-1:0]   r_f_op2     [NCH][DEPTH];
    logic [TW-1:0]   r_f_tag     [NCH][DEPTH];
    logic [PW-1:0]   r_wr_ptr    [NCH];
    logic [PW-1:0]   r_rd_ptr    [NCH];
    logic [CW-1:0]   r_count     [NCH];

    logic [3:0]      w_head_cmd  [NCH];
    logic [DW-1:0]   w_head_op1  [NCH];
    logic [DW-1:0]   w_head_op2  [NCH];
    logic [TW-1:0]   w_head_tag  [NCH];

    logic [RW-1:0]   r_rr_arith;
    logic [RW-1:0]   r_rr_shift;
    logic [1:0]      r_resp      [NCH];
    logic [DW-1:0]   r_data      [NCH];
    logic [TW-1:0]   r_tag       [NCH];

    logic [NCH-1:0]  w_busy;
    logic [NCH-1:0]  w_accept;
    logic [NCH-1:0]  w_push;
    logic [NCH-1:0]  w_pop;
    logic [NCH-1:0]  w_elig_arith;
    logic [NCH-1:0]  w_elig_shift;
    logic [RW:0]     w_pick_arith;
    logic [RW:0]     w_pick_shift;
    logic [DW+1:0]   w_res_arith;
    logic [DW+1:0]   w_res_shift;

    // Per-channel occupancy, FIFO head decode and capture-FSM next state.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_busy[c]       = ({1'b0, r_count[c]} + {{CW{1'b0}}, (r_state[c] == ST_OP2)})
                              >= (CW + 1)'(DEPTH);
            w_head_cmd[c]   = r_f_cmd[c][r_rd_ptr[c]];
            w_head_op1[c]   = r_f_op1[c][r_rd_ptr[c]];
            w_head_op2[c]   = r_f_op2[c][r_rd_ptr[c]];
            w_head_tag[c]   = r_f_tag[c][r_rd_ptr[c]];
            w_elig_shift[c] = (r_count[c] != '0) &&
                              ((w_head_cmd[c] == CMD_SHL) || (w_head_cmd[c] == CMD_SHR));
            w_elig_arith[c] = (r_count[c] != '0) &&
                              (w_head_cmd[c] != CMD_SHL) && (w_head_cmd[c] != CMD_SHR);
            w_push[c]       = (r_state[c] == ST_OP2);
            w_accept[c]     = (r_state[c] == ST_IDLE) && (req_cmd_in[c*4 +: 4] != 4'd0) &&
                              !w_busy[c];
            case (r_state[c])
                ST_IDLE: w_state_nxt[c] = w_accept[c] ? ST_OP2 : ST_IDLE;
                ST_OP2:  w_state_nxt[c] = ST_IDLE;
                default: w_state_nxt[c] = ST_IDLE;
            endcase
        end
    end

    // Unit arbitration, execution of the granted heads and pop strobes.
    always_comb begin
        w_pick_arith = rr_pick(w_elig_arith, r_rr_arith);
        w_pick_shift = rr_pick(w_elig_shift, r_rr_shift);
        w_res_arith  = calc_exec(w_head_cmd[w_pick_arith[RW-1:0]],
                                 w_head_op1[w_pick_arith[RW-1:0]],
                                 w_head_op2[w_pick_arith[RW-1:0]]);
        w_res_shift  = calc_exec(w_head_cmd[w_pick_shift[RW-1:0]],
                                 w_head_op1[w_pick_shift[RW-1:0]],
                                 w_head_op2[w_pick_shift[RW-1:0]]);
        for (int c = 0; c < NCH; c++) begin
            w_pop[c] = (w_pick_arith[RW] && (w_pick_arith[RW-1:0] == RW'(c))) ||
                       (w_pick_shift[RW] && (w_pick_shift[RW-1:0] == RW'(c)));
        end
    end

    // Capture FSM state register.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_state[c] <= ST_IDLE;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                r_state[c] <= w_state_nxt[c];
            end
        end
    end

    // Command, op1 and tag latched in the command cycle.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_cap_cmd[c] <= 4'd0;
                r_cap_op1[c] <= '0;
                r_cap_tag[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_accept[c]) begin
                    r_cap_cmd[c] <= req_cmd_in[c*4 +: 4];
                    r_cap_op1[c] <= req_data_in[c*DW +: DW];
                    r_cap_tag[c] <= req_tag_in[c*TW +: TW];
                end else begin
                    r_cap_cmd[c] <= r_cap_cmd[c];
                    r_cap_op1[c] <= r_cap_op1[c];
                    r_cap_tag[c] <= r_cap_tag[c];
                end
            end
        end
    end

    // Command FIFOs: the push happens in the op2 cycle, pops follow the unit grants.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                r_count[c]  <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_f_cmd[c][i] <= 4'd0;
                    r_f_op1[c][i] <= '0;
                    r_f_op2[c][i] <= '0;
                    r_f_tag[c][i] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_push[c]) begin
                    r_f_cmd[c][r_wr_ptr[c]] <= r_cap_cmd[c];
                    r_f_op1[c][r_wr_ptr[c]] <= r_cap_op1[c];
                    r_f_op2[c][r_wr_ptr[c]] <= req_data_in[c*DW +: DW];
                    r_f_tag[c][r_wr_ptr[c]] <= r_cap_tag[c];
                end else begin
                    r_f_cmd[c][r_wr_ptr[c]] <= r_f_cmd[c][r_wr_ptr[c]];
                end
                r_wr_ptr[c] <= r_wr_ptr[c] + PW'(w_push[c]);
                r_rd_ptr[c] <= r_rd_ptr[c] + PW'(w_pop[c]);
                r_count[c]  <= r_count[c] + CW'(w_push[c]) - CW'(w_pop[c]);
            end
        end
    end

    // Round-robin pointers advance past the channel that was just granted.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_rr_arith <= '0;
            r_rr_shift <= '0;
        end else begin
            if (w_pick_arith[RW]) begin
                r_rr_arith <= rr_next(w_pick_arith[RW-1:0]);
            end else begin
                r_rr_arith <= r_rr_arith;
            end
            if (w_pick_shift[RW]) begin
                r_rr_shift <= rr_next(w_pick_shift[RW-1:0]);
            end else begin
                r_rr_shift <= r_rr_shift;
            end
        end
    end

    // Registered responses; a channel can hold at most one grant per cycle.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_resp[c] <= 2'd0;
                r_data[c] <= '0;
                r_tag[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_pick_arith[RW] && (w_pick_arith[RW-1:0] == RW'(c))) begin
                    r_resp[c] <= w_res_arith[DW+1:DW];
                    r_data[c] <= w_res_arith[DW-1:0];
                    r_tag[c]  <= w_head_tag[c];
                end else if (w_pick_shift[RW] && (w_pick_shift[RW-1:0] == RW'(c))) begin
                    r_resp[c] <= w_res_shift[DW+1:DW];
                    r_data[c] <= w_res_shift[DW-1:0];
                    r_tag[c]  <= w_head_tag[c];
                end else begin
                    r_resp[c] <= 2'd0;
                    r_data[c] <= '0;
                    r_tag[c]  <= '0;
                end
            end
        end
    end

    assign req_busy = w_busy;

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign out_resp[g*2 +: 2]   = r_resp[g];
        assign out_data[g*DW +: DW] = r_data[g];
        assign out_tag[g*TW +: TW]  = r_tag[g];
    end

endmodule

// File: tb/tb_calc_rr_engine.sv
// Bench for calc_rr_engine: directed vector table, hand-written multi-cycle sequences and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_calc_rr_engine;

    localparam int NCH   = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TW    = 2;

    logic                c_clk = 1'b0;
    logic                reset;
    logic [NCH*4-1:0]    req_cmd_in;
    logic [NCH*DW-1:0]   req_data_in;
    logic [NCH*TW-1:0]   req_tag_in;
    logic [NCH-1:0]      req_busy;
    logic [NCH*2-1:0]    out_resp;
    logic [NCH*DW-1:0]   out_data;
    logic [NCH*TW-1:0]   out_tag;

    calc_rr_engine #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .TW(TW)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .req_tag_in  (req_tag_in),
        .req_busy    (req_busy),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .out_tag     (out_tag)
    );

    always #5 c_clk = ~c_clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [3:0] cmd, input logic [31:0] d,
                          input logic [1:0] t);
        req_cmd_in[c*4 +: 4]   = cmd;
        req_data_in[c*DW +: DW] = d;
        req_tag_in[c*TW +: TW]  = t;
    endtask

    task automatic clear_inputs();
        req_cmd_in  = '0;
        req_data_in = '0;
        req_tag_in  = '0;
    endtask

    // Expected per-channel outputs given as arrays; one comparison per field per channel.
    task automatic chk_outs(input string name, input logic [1:0] er [NCH],
                            input logic [31:0] ed [NCH], input logic [1:0] et [NCH]);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("%s ch%0d resp", name, c), 64'(out_resp[c*2 +: 2]), 64'(er[c]));
            chk($sformatf("%s ch%0d data", name, c), 64'(out_data[c*DW +: DW]), 64'(ed[c]));
            chk($sformatf("%s ch%0d tag", name, c), 64'(out_tag[c*TW +: TW]), 64'(et[c]));
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, " out_resp"}, 64'(out_resp), 64'd0);
        chk({name, " out_data"}, 64'(out_data), 64'd0);
        chk({name, " out_tag"}, 64'(out_tag), 64'd0);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  tag;
    } mcmd_t;

    mcmd_t       mq [NCH][$];
    bit          m_pend [NCH];
    mcmd_t       m_cap [NCH];
    int          m_rr_a, m_rr_s;
    logic [1:0]  e_resp [NCH];
    logic [31:0] e_data [NCH];
    logic [1:0]  e_tag  [NCH];
    bit          drv_data_phase [NCH];
    int          ch0_drops;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            m_pend[c] = 1'b0;
            e_resp[c] = 2'd0;
            e_data[c] = 32'd0;
            e_tag[c]  = 2'd0;
            drv_data_phase[c] = 1'b0;
        end
        m_rr_a = 0;
        m_rr_s = 0;
    endtask

    function automatic bit m_busy(input int c);
        return (mq[c].size() + int'(m_pend[c])) >= DEPTH;
    endfunction

    function automatic bit is_shift(input logic [3:0] cmd);
        return (cmd == 4'd5) || (cmd == 4'd6);
    endfunction

    task automatic model_eval(input mcmd_t m, output logic [1:0] r, output logic [31:0] d);
        longint unsigned a, b;
        a = 64'(m.op1);
        b = 64'(m.op2);
        r = 2'd2;
        d = 32'd0;
        if (m.cmd == 4'd1) begin
            if (a + b <= 64'hFFFF_FFFF) begin r = 2'd1; d = 32'(a + b); end
        end else if (m.cmd == 4'd2) begin
            if (b <= a) begin r = 2'd1; d = 32'(a - b); end
        end else if (m.cmd == 4'd5) begin
            r = 2'd1; d = 32'((a << (b % 64'd32)) & 64'hFFFF_FFFF);
        end else if (m.cmd == 4'd6) begin
            r = 2'd1; d = 32'(a >> (b % 64'd32));
        end
    endtask

    // Advance the model across one clock edge with the inputs currently driven.
    task automatic model_step();
        bit busy_now [NCH];
        int ga, gs, i;
        for (int c = 0; c < NCH; c++) begin
            busy_now[c] = m_busy(c);
            e_resp[c] = 2'd0;
            e_data[c] = 32'd0;
            e_tag[c]  = 2'd0;
        end
        ga = -1;
        gs = -1;
        for (int k = 0; k < NCH; k++) begin
            i = (m_rr_a + k) % NCH;
            if (ga < 0 && mq[i].size() > 0 && !is_shift(mq[i][0].cmd)) ga = i;
            i = (m_rr_s + k) % NCH;
            if (gs < 0 && mq[i].size() > 0 && is_shift(mq[i][0].cmd)) gs = i;
        end
        if (ga >= 0) begin
            model_eval(mq[ga][0], e_resp[ga], e_data[ga]);
            e_tag[ga] = mq[ga][0].tag;
            void'(mq[ga].pop_front());
            m_rr_a = (ga + 1) % NCH;
        end
        if (gs >= 0) begin
            model_eval(mq[gs][0], e_resp[gs], e_data[gs]);
            e_tag[gs] = mq[gs][0].tag;
            void'(mq[gs].pop_front());
            m_rr_s = (gs + 1) % NCH;
        end
        for (int c = 0; c < NCH; c++) begin
            if (m_pend[c]) begin
                m_cap[c].op2 = req_data_in[c*DW +: DW];
                mq[c].push_back(m_cap[c]);
                m_pend[c] = 1'b0;
            end else if (req_cmd_in[c*4 +: 4] != 4'd0 && !busy_now[c]) begin
                m_pend[c]    = 1'b1;
                m_cap[c].cmd = req_cmd_in[c*4 +: 4];
                m_cap[c].op1 = req_data_in[c*DW +: DW];
                m_cap[c].tag = req_tag_in[c*TW +: TW];
            end else if (req_cmd_in[c*4 +: 4] != 4'd0 && c == 0) begin
                ch0_drops++;
            end
        end
    endtask

    function automatic logic [3:0] pick_cmd(input int mix);
        int r;
        r = $urandom_range(0, 9);
        if (mix == 1) return (r < 6) ? 4'd1 : 4'd2;
        if (mix == 2) return (r < 5) ? 4'd5 : 4'd6;
        if (r < 3) return 4'd1;
        if (r < 5) return 4'd2;
        if (r < 7) return 4'd5;
        if (r < 9) return 4'd6;
        return 4'($urandom_range(1, 15));
    endfunction

    // Randomized traffic: rate is the percent chance a free channel issues a command.
    task automatic run_model(input int cycles, input int rate, input int mix);
        for (int cyc = 0; cyc < cycles; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("rnd cyc%0d ch%0d resp", cyc, c), 64'(out_resp[c*2 +: 2]), 64'(e_resp[c]));
                chk($sformatf("rnd cyc%0d ch%0d data", cyc, c), 64'(out_data[c*DW +: DW]), 64'(e_data[c]));
                chk($sformatf("rnd cyc%0d ch%0d tag", cyc, c), 64'(out_tag[c*TW +: TW]), 64'(e_tag[c]));
                chk($sformatf("rnd cyc%0d ch%0d busy", cyc, c), 64'(req_busy[c]), 64'(m_busy(c)));
            end
            for (int c = 0; c < NCH; c++) begin
                if (drv_data_phase[c]) begin
                    // junk command in an accepted op2 cycle must be ignored
                    set_ch(c, m_pend[c] ? 4'($urandom_range(1, 15)) : 4'd0, $urandom, 2'($urandom));
                    drv_data_phase[c] = 1'b0;
                end else if (int'($urandom_range(0, 99)) < rate) begin
                    set_ch(c, pick_cmd(mix), $urandom, 2'($urandom));
                    drv_data_phase[c] = 1'b1;
                end else begin
                    set_ch(c, 4'd0, $urandom, 2'($urandom));
                end
            end
            model_step();
            tick();
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        #1;
        chk_idle("reset");
        chk("reset req_busy", 64'(req_busy), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int          ch;
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  tag;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [11];

    // All four channels issue ADD together; grants follow ch0..ch3 from rr_ptr 0.
    task automatic all_add(input string name);
        logic [1:0]  er [NCH];
        logic [31:0] ed [NCH];
        logic [1:0]  et [NCH];
        for (int c = 0; c < NCH; c++) set_ch(c, 4'd1, 32'(c + 1), 2'(c));
        tick();
        for (int c = 0; c < NCH; c++) set_ch(c, 4'd0, 32'd100, 2'd0);
        tick();
        clear_inputs();
        tick();
        for (int k = 0; k < NCH; k++) begin
            for (int c = 0; c < NCH; c++) begin
                er[c] = (c == k) ? 2'd1 : 2'd0;
                ed[c] = (c == k) ? 32'(101 + c) : 32'd0;
                et[c] = (c == k) ? 2'(c) : 2'd0;
            end
            chk_outs($sformatf("%s slot%0d", name, k), er, ed, et);
            tick();
        end
        chk_idle({name, " after"});
    endtask

    initial begin
        logic [1:0]  er [NCH];
        logic [31:0] ed [NCH];
        logic [1:0]  et [NCH];

        vecs[0]  = '{0, 4'd1,  32'd5,          32'd7,          2'd1, 2'd1, 32'd12};
        vecs[1]  = '{1, 4'd1,  32'hFFFF_FFFF,  32'd1,          2'd2, 2'd2, 32'd0};
        vecs[2]  = '{1, 4'd2,  32'd3,          32'd4,          2'd3, 2'd2, 32'd0};
        vecs[3]  = '{1, 4'd2,  32'd4,          32'd3,          2'd0, 2'd1, 32'd1};
        vecs[4]  = '{1, 4'd9,  32'd8,          32'd8,          2'd1, 2'd2, 32'd0};
        vecs[5]  = '{2, 4'd5,  32'd1,          32'd31,         2'd2, 2'd1, 32'h8000_0000};
        vecs[6]  = '{2, 4'd6,  32'h8000_0000,  32'd33,         2'd3, 2'd1, 32'h4000_0000};
        vecs[7]  = '{3, 4'd1,  32'h7FFF_FFFF,  32'h8000_0000,  2'd0, 2'd1, 32'hFFFF_FFFF};
        vecs[8]  = '{3, 4'd2,  32'd7,          32'd7,          2'd1, 2'd1, 32'd0};
        vecs[9]  = '{0, 4'd15, 32'd1,          32'd2,          2'd3, 2'd2, 32'd0};
        vecs[10] = '{3, 4'd6,  32'h0000_00F0,  32'd0,          2'd2, 2'd1, 32'h0000_00F0};

        reset = 1'b1;
        clear_inputs();
        ch0_drops = 0;
        #3;
        do_reset();

        foreach (vecs[i]) begin
            set_ch(vecs[i].ch, vecs[i].cmd, vecs[i].op1, vecs[i].tag);
            tick();
            set_ch(vecs[i].ch, 4'd0, vecs[i].op2, 2'd0);
            tick();
            clear_inputs();
            tick();
            for (int c = 0; c < NCH; c++) begin
                er[c] = (c == vecs[i].ch) ? vecs[i].resp : 2'd0;
                ed[c] = (c == vecs[i].ch) ? vecs[i].data : 32'd0;
                et[c] = (c == vecs[i].ch) ? vecs[i].tag  : 2'd0;
            end
            chk_outs($sformatf("vec%0d", i), er, ed, et);
            tick();
            chk_idle($sformatf("vec%0d T+4", i));
        end

        do_reset();
        all_add("add4 first");
        all_add("add4 repeat");

        // ADD on ch0 and SHL on ch1 use different units and answer together.
        set_ch(0, 4'd1, 32'd10, 2'd2);
        set_ch(1, 4'd5, 32'd3, 2'd1);
        tick();
        set_ch(0, 4'd0, 32'd20, 2'd0);
        set_ch(1, 4'd0, 32'd4, 2'd0);
        tick();
        clear_inputs();
        tick();
        for (int c = 0; c < NCH; c++) begin
            er[c] = (c < 2) ? 2'd1 : 2'd0;
            ed[c] = (c == 0) ? 32'd30 : ((c == 1) ? 32'd48 : 32'd0);
            et[c] = (c == 0) ? 2'd2 : ((c == 1) ? 2'd1 : 2'd0);
        end
        chk_outs("dual unit", er, ed, et);
        tick();
        chk_idle("dual unit T+4");

        // Reset in the middle of OP2 discards the command.
        set_ch(0, 4'd1, 32'd9, 2'd2);
        tick();
        set_ch(0, 4'd0, 32'd9, 2'd0);
        reset = 1'b0;
        #1;
        chk_idle("mid-op2 reset");
        chk("mid-op2 reset req_busy", 64'(req_busy), 64'd0);
        tick();
        reset = 1'b1;
        clear_inputs();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_idle($sformatf("post-reset quiet%0d", k));
        end
        set_ch(0, 4'd1, 32'd2, 2'd1);
        tick();
        set_ch(0, 4'd0, 32'd2, 2'd0);
        tick();
        clear_inputs();
        tick();
        for (int c = 0; c < NCH; c++) begin
            er[c] = (c == 0) ? 2'd1 : 2'd0;
            ed[c] = (c == 0) ? 32'd4 : 32'd0;
            et[c] = (c == 0) ? 2'd1 : 2'd0;
        end
        chk_outs("post-reset add", er, ed, et);
        tick();

        // Randomized traffic against the model, including saturation of the arith unit.
        do_reset();
        run_model(1500, 60, 0);
        run_model(200, 100, 1);
        chk("ch0 busy drop seen", 64'(ch0_drops > 0), 64'd1);
        run_model(300, 100, 2);
        run_model(40, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
